arbitro_memoria: RTL and testbench



---
 rtl/arbitro_memoria_pkg.sv | 22 ++
 rtl/arbitro_memoria_if.sv | 40 ++++
 rtl/arbitro_memoria_selector_rr.sv | 23 ++
 rtl/arbitro_memoria.sv | 112 +++++++++++
 tb/tb_arbitro_memoria.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_memoria_pkg.sv
// rtl/arbitro_memoria_pkg.sv - shared types and defaults for the memory arbiter
package arbitro_memoria_pkg;

  localparam int DW_DEF = 64;
  localparam int AW_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } grant_t;

  function automatic grant_t other_side(input grant_t g);
    return (g == INSTR) ? DATA : INSTR;
  endfunction

endpackage

// File: rtl/arbitro_memoria_if.sv
// rtl/arbitro_memoria_if.sv - requester handshakes plus the shared memory port
interface arbitro_memoria_if
  import arbitro_memoria_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  logic          busy;

  // The arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    output i_ack, i_rdata, d_ack, d_rdata, mem_we, mem_a, mem_wd, busy
  );

  // Requesters and the memory, seen from outside the arbiter.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_we, mem_a, mem_wd, busy
  );

endinterface

// File: rtl/arbitro_memoria_selector_rr.sv
// rtl/arbitro_memoria_selector_rr.sv - combinational two-way round-robin picker
module arbitro_memoria_selector_rr
  import arbitro_memoria_pkg::*;
(
  input  logic   i_req_i,
  input  logic   d_req_i,
  input  grant_t last_grant_i,
  output logic   grant_valid_o,
  output grant_t grant_o
);

  always_comb begin
    grant_valid_o = i_req_i | d_req_i;
    grant_o       = INSTR;
    // On a tie the side that did not win last time goes next.
    if (i_req_i && d_req_i) begin
      grant_o = other_side(last_grant_i);
    end else if (d_req_i) begin
      grant_o = DATA;
    end
  end

endmodule

// File: rtl/arbitro_memoria.sv
// rtl/arbitro_memoria.sv - shares one data memory between fetch and load/store
// One access cycle per transaction, registered read data and a one-cycle ack.
module arbitro_memoria
  import arbitro_memoria_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
)(
  input logic               clk,
  input logic               reset,
  arbitro_memoria_if.slave  bus
);

  state_t        state_q;
  grant_t        last_grant_q;
  grant_t        grant_q;
  logic          we_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_a_q;
  logic [DW-1:0] mem_wd_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          i_ack_q;
  logic          d_ack_q;
  logic          busy_q;

  logic          grant_valid;
  grant_t        grant_sel;

  arbitro_memoria_selector_rr u_selector_rr (
    .i_req_i       (bus.i_req),
    .d_req_i       (bus.d_req),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_o       (grant_sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= INSTR;
      grant_q      <= INSTR;
      we_q         <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_a_q      <= '0;
      mem_wd_q     <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            grant_q      <= grant_sel;
            last_grant_q <= grant_sel;
            busy_q       <= 1'b1;
            state_q      <= ACCESS;
            if (grant_sel == DATA) begin
              mem_a_q  <= bus.d_addr;
              mem_wd_q <= bus.d_wdata;
              we_q     <= bus.d_we;
              mem_we_q <= bus.d_we;
            end else begin
              mem_a_q  <= bus.i_addr;
              we_q     <= 1'b0;
              mem_we_q <= 1'b0;
            end
          end
        end
        ACCESS: begin
          // The memory commits a store on this edge; reads are captured here.
          mem_we_q <= 1'b0;
          if (!we_q) begin
            if (grant_q == DATA) begin
              d_rdata_q <= bus.mem_rd;
            end else begin
              i_rdata_q <= bus.mem_rd;
            end
          end
          i_ack_q <= (grant_q == INSTR);
          d_ack_q <= (grant_q == DATA);
          state_q <= RESP;
        end
        RESP: begin
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          mem_we_q <= 1'b0;
          i_ack_q  <= 1'b0;
          d_ack_q  <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_we  = mem_we_q;
  assign bus.mem_a   = mem_a_q;
  assign bus.mem_wd  = mem_wd_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// tb/tb_arbitro_memoria.sv - directed scoreboard bench for the memory arbiter
module tb_arbitro_memoria;

  logic clk;
  logic reset;
  logic preload;

  arbitro_memoria_if #(.DW(64), .AW(64)) bus ();

  arbitro_memoria #(.DW(64), .AW(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] mem [0:31];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 64'd0;
      mem[1] <= 64'h00A00093;
      mem[7] <= 64'h1;
    end else if (bus.mem_we) begin
      mem[bus.mem_a[4:0]] <= bus.mem_wd;
    end
  end

  assign bus.mem_rd = mem[bus.mem_a[4:0]];

  typedef struct {
    logic        is_data;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sb [$];
  logic [63:0] ref_mem [0:31];
  logic [63:0] model_d_rdata;
  logic        model_last;
  int          cyc;
  int          n_vec;
  int          n_err;

  localparam logic [63:0] STORE_VAL = 64'hDEADBEEFCAFEF00D;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t  e;
    string tg;
    @(posedge clk);
    #1;
    cyc++;
    chk1("ack_exclusive", bus.i_ack & bus.d_ack, 1'b0);
    if (bus.i_ack || bus.d_ack) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", {62'd0, bus.i_ack, bus.d_ack}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk1("ack_side", bus.d_ack, e.is_data);
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
        tg = e.is_data ? "d_rdata" : "i_rdata";
        chk(tg, e.is_data ? bus.d_rdata : bus.i_rdata, e.rdata);
      end
    end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("missing_ack", 64'(cyc), 64'(e.cyc));
    end
  endtask

  task automatic push_txn(input logic is_data, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata, input int ack_cyc);
    exp_t e;
    e.is_data = is_data;
    e.cyc     = ack_cyc;
    if (is_data && we) begin
      ref_mem[addr[4:0]] = wdata;
      e.rdata = model_d_rdata;
    end else begin
      e.rdata = ref_mem[addr[4:0]];
      if (is_data) model_d_rdata = e.rdata;
    end
    model_last = is_data;
    sb.push_back(e);
  endtask

  task automatic do_txn(input logic is_data, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata);
    if (is_data) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    push_txn(is_data, is_data & we, addr, wdata, cyc + 2);
    tick();
    chk("access_mem_a", bus.mem_a, addr);
    chk1("access_mem_we", bus.mem_we, is_data & we);
    chk1("access_busy", bus.busy, 1'b1);
    tick();
    chk1("resp_mem_we", bus.mem_we, 1'b0);
    chk1("resp_busy", bus.busy, 1'b1);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick();
    chk1("idle_busy", bus.busy, 1'b0);
    chk1("idle_mem_we", bus.mem_we, 1'b0);
  endtask

  initial begin
    int c;
    logic w;
    n_vec = 0; n_err = 0; cyc = 0;
    reset = 1'b1; preload = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 64'd0;
    ref_mem[1] = 64'h00A00093;
    ref_mem[7] = 64'h1;
    model_d_rdata = 64'd0;
    model_last = 1'b0;

    tick();
    tick();
    chk1("rst_i_ack", bus.i_ack, 1'b0);
    chk1("rst_d_ack", bus.d_ack, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk("rst_mem_a", bus.mem_a, 64'd0);
    chk("rst_mem_wd", bus.mem_wd, 64'd0);
    chk("rst_i_rdata", bus.i_rdata, 64'd0);
    chk("rst_d_rdata", bus.d_rdata, 64'd0);
    reset = 1'b0;
    preload = 1'b0;
    tick();

    // Single fetch, then store and load of the same word.
    do_txn(1'b0, 1'b0, 64'd1, 64'd0);
    do_txn(1'b1, 1'b1, 64'd5, STORE_VAL);
    chk("store_mem_wd", bus.mem_wd, STORE_VAL);
    do_txn(1'b1, 1'b0, 64'd5, 64'd0);

    // Load requester gives up during ACCESS; the transaction still completes once.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'd1;
    push_txn(1'b1, 1'b0, 64'd1, 64'd0, cyc + 2);
    tick();
    bus.d_req = 1'b0;
    for (int t = 0; t < 4; t++) tick();
    chk1("drop_busy", bus.busy, 1'b0);
    chk("drop_sb_empty", 64'(sb.size()), 64'd0);

    // Continuous contention: fetch from 1, load from 5.
    bus.i_req = 1'b1; bus.i_addr = 64'd1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'd5;
    c = cyc;
    for (int k = 0; k < 20; k++) begin
      w = ~model_last;
      push_txn(w, 1'b0, w ? 64'd5 : 64'd1, 64'd0, c + 2 + 3 * k);
    end
    for (int t = 1; t <= 59; t++) begin
      tick();
      chk1("contend_busy", bus.busy, (t % 3) != 0);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick();
    chk1("contend_end_busy", bus.busy, 1'b0);
    chk("contend_sb_empty", 64'(sb.size()), 64'd0);

    // Reset lands in the ACCESS cycle of a store to word 7.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'd7; bus.d_wdata = 64'h5555AAAA5555AAAA;
    tick();
    chk1("abort_access_we", bus.mem_we, 1'b1);
    bus.d_req = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk1("abort_mem_we", bus.mem_we, 1'b0);
    chk1("abort_busy", bus.busy, 1'b0);
    chk("abort_mem_a", bus.mem_a, 64'd0);
    chk("abort_d_rdata", bus.d_rdata, 64'd0);
    model_d_rdata = 64'd0;
    model_last = 1'b0;
    tick();
    tick();
    chk("abort_mem7", mem[7], ref_mem[7]);
    reset = 1'b0;
    tick();

    // Ties: the winner follows the round-robin pointer, the loser is served next.
    for (int r = 0; r < 2; r++) begin
      bus.i_req = 1'b1; bus.i_addr = 64'd1;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'd5;
      c = cyc;
      w = ~model_last;
      push_txn(w, 1'b0, w ? 64'd5 : 64'd1, 64'd0, c + 2);
      push_txn(~w, 1'b0, w ? 64'd1 : 64'd5, 64'd0, c + 5);
      tick();
      tick();
      if (w) bus.d_req = 1'b0; else bus.i_req = 1'b0;
      tick();
      tick();
      tick();
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      tick();
    end
    tick();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    chk("final_mem7", mem[7], 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
